// File: rtl/spad_bank_stomach.sv
// Single-bank scratchpad access stage: zeroes the bank after reset, then performs one
// byte-masked write or read per cycle and returns tagged results after READ_LAT cycles.
module spad_bank_stomach #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned READ_LAT = 2,
  parameter int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_src,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wmask,
  output logic                  res_valid,
  output logic                  res_write,
  output logic                  res_src,
  output logic [DATA_W-1:0]     res_rdata,
  output logic                  init_busy
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned LAST  = READ_LAT - 1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ready_q;
  logic                busy_q;
  logic                accept;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                vld_q [READ_LAT];
  logic                wr_q  [READ_LAT];
  logic                src_q [READ_LAT];
  logic [DATA_W-1:0]   dat_q [READ_LAT];

  // Reset has priority: nothing issued on a reset edge may touch storage or the pipe.
  assign accept = req_valid && ready_q && !rst;

  // Init sequencer: walk the bank once, then run until the next reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == ST_RUN);
      busy_q  <= (state_d == ST_INIT);
    end
  end

  // Bank storage: clear word during init, byte-masked write once running.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_INIT) begin
      mem_q[cnt_q] <= '0;
    end else if (accept && req_write) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (req_wmask[b]) begin
          mem_q[req_addr][b*8 +: 8] <= req_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Result pipe; empty stages carry all-zero payload so outputs idle at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        vld_q[i] <= 1'b0;
        wr_q[i]  <= 1'b0;
        src_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= accept;
      wr_q[0]  <= accept && req_write;
      src_q[0] <= accept && req_src;
      dat_q[0] <= (accept && !req_write) ? mem_q[req_addr] : '0;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        wr_q[i]  <= wr_q[i-1];
        src_q[i] <= src_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign req_ready = ready_q;
  assign init_busy = busy_q;
  assign res_valid = vld_q[LAST];
  assign res_write = wr_q[LAST];
  assign res_src   = src_q[LAST];
  assign res_rdata = dat_q[LAST];

endmodule
